// File: rtl/execution_pipe_if.sv
// EX-stage bus: upstream op + controls (slave side inputs) and the EX/MEM register outputs.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface execution_pipe_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int INST_MEM_WIDTH = 16
);
    logic                      flush;
    logic                      in_valid, in_ready;
    logic                      out_valid, out_ready;
    logic                      RegWrite, MemWrite, MemRead, UARTtoReg;
    logic [1:0]                MemtoReg, Branch, ALUSrcs, RegDist;
    logic                      ALUSrcs2;
    logic [3:0]                ALUOp;
    logic [DATA_WIDTH-1:0]     op1_sub, op2_sub;
    logic [4:0]                rt, rd, sa;
    logic [15:0]               immediate;
    logic [25:0]               inst_index;
    logic [INST_MEM_WIDTH-1:0] pc, pc1;
    logic                      RegWrite_next, MemWrite_next, MemRead_next, UARTtoReg_next;
    logic [1:0]                MemtoReg_next, Branch_next;
    logic [25:0]               inst_index_next;
    logic [INST_MEM_WIDTH-1:0] pc_next, pc1_next, pc2;
    logic [DATA_WIDTH-1:0]     register_data, alu_result;
    logic [4:0]                rdist;

    modport slave (
        input  flush, in_valid, out_ready,
        input  RegWrite, MemWrite, MemRead, UARTtoReg, MemtoReg, Branch,
        input  ALUSrcs, ALUSrcs2, ALUOp, RegDist, op1_sub, op2_sub,
        input  rt, rd, sa, immediate, inst_index, pc, pc1,
        output in_ready, out_valid,
        output RegWrite_next, MemWrite_next, MemRead_next, UARTtoReg_next,
        output MemtoReg_next, Branch_next, inst_index_next, pc_next, pc1_next,
        output register_data, alu_result, rdist, pc2
    );

    modport master (
        output flush, in_valid, out_ready,
        output RegWrite, MemWrite, MemRead, UARTtoReg, MemtoReg, Branch,
        output ALUSrcs, ALUSrcs2, ALUOp, RegDist, op1_sub, op2_sub,
        output rt, rd, sa, immediate, inst_index, pc, pc1,
        input  in_ready, out_valid,
        input  RegWrite_next, MemWrite_next, MemRead_next, UARTtoReg_next,
        input  MemtoReg_next, Branch_next, inst_index_next, pc_next, pc1_next,
        input  register_data, alu_result, rdist, pc2
    );
endinterface

// File: rtl/execution_pipe.sv
// Registered EX stage with valid/ready handshake, flush, multi-cycle MUL and
// a restoring unsigned divider (one quotient bit per cycle).
module execution_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int INST_MEM_WIDTH = 16,
    parameter int MUL_LAT        = 3
) (
    input logic             clk,
    input logic             rstd,
    execution_pipe_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + MUL_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [CW-1:0] DIV_CNT = CW'(DATA_WIDTH - 1);
    localparam logic [3:0] OP_MUL = 4'd11, OP_DIVU = 4'd12, OP_REMU = 4'd13;

    typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] op1, op2, alu_res, fin_res;
    logic [DATA_WIDTH-1:0] quo, dvs, rem, quo_n, rem_n;
    logic [DATA_WIDTH:0]   r_sh, diff;
    logic [CW-1:0]         cnt;
    logic [3:0]            busy_op;
    logic [4:0]            shamt;
    logic                  ready, accept, multi, ge;

    assign ready         = !bus.flush && state != BUSY && (state != HOLD || bus.out_ready);
    assign accept        = bus.in_valid && ready;
    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == HOLD);
    assign multi = (bus.ALUOp == OP_MUL && MUL_LAT > 1) || bus.ALUOp == OP_DIVU || bus.ALUOp == OP_REMU;

    always_comb begin
        case (bus.ALUSrcs)
            2'd0:    op2 = bus.op2_sub;
            2'd1:    op2 = {{(DATA_WIDTH-5){1'b0}}, bus.sa};
            2'd2:    op2 = {{(DATA_WIDTH-16){bus.immediate[15]}}, bus.immediate};
            default: op2 = {{(DATA_WIDTH-16){1'b0}}, bus.immediate};
        endcase
        op1   = bus.ALUSrcs2 ? bus.op2_sub : bus.op1_sub;
        shamt = op2[4:0];
        case (bus.ALUOp)
            4'd0:    alu_res = op1 + op2;
            4'd1:    alu_res = op1 - op2;
            4'd2:    alu_res = op1 & op2;
            4'd3:    alu_res = op1 | op2;
            4'd4:    alu_res = op1 ^ op2;
            4'd5:    alu_res = ~(op1 | op2);
            4'd6:    alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'd7:    alu_res = op1 << shamt;
            4'd8:    alu_res = op1 >> shamt;
            4'd9:    alu_res = DATA_WIDTH'($signed(op1) >>> shamt);
            4'd10:   alu_res = op2 << 16;
            4'd11:   alu_res = op1 * op2;
            default: alu_res = '0;
        endcase
    end

    // Divider step: quo shifts the dividend out MSB-first while quotient bits shift in.
    always_comb begin
        r_sh  = {rem, quo[DATA_WIDTH-1]};
        diff  = r_sh - {1'b0, dvs};
        ge    = r_sh >= {1'b0, dvs};
        rem_n = ge ? diff[DATA_WIDTH-1:0] : r_sh[DATA_WIDTH-1:0];
        quo_n = {quo[DATA_WIDTH-2:0], ge};
        case (busy_op)
            OP_DIVU: fin_res = quo_n;
            OP_REMU: fin_res = rem_n;
            default: fin_res = quo * dvs;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, HOLD: begin
                if (accept)                             state_nxt = multi ? BUSY : HOLD;
                else if (state == HOLD && bus.out_ready) state_nxt = IDLE;
            end
            BUSY:    if (cnt == '0) state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            state               <= IDLE;
            {quo, dvs, rem}     <= '0;
            cnt                 <= '0;
            busy_op             <= '0;
            bus.RegWrite_next   <= 1'b0;
            bus.MemWrite_next   <= 1'b0;
            bus.MemRead_next    <= 1'b0;
            bus.UARTtoReg_next  <= 1'b0;
            bus.MemtoReg_next   <= '0;
            bus.Branch_next     <= '0;
            bus.inst_index_next <= '0;
            bus.pc_next         <= '0;
            bus.pc1_next        <= '0;
            bus.pc2             <= '0;
            bus.register_data   <= '0;
            bus.alu_result      <= '0;
            bus.rdist           <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus.RegWrite_next   <= bus.RegWrite;
                bus.MemWrite_next   <= bus.MemWrite;
                bus.MemRead_next    <= bus.MemRead;
                bus.UARTtoReg_next  <= bus.UARTtoReg;
                bus.MemtoReg_next   <= bus.MemtoReg;
                bus.Branch_next     <= bus.Branch;
                bus.inst_index_next <= bus.inst_index;
                bus.pc_next         <= bus.pc;
                bus.pc1_next        <= bus.pc1;
                bus.pc2             <= bus.pc + INST_MEM_WIDTH'($signed(bus.immediate));
                bus.register_data   <= bus.op1_sub;
                case (bus.RegDist)
                    2'd0:    bus.rdist <= bus.rt;
                    2'd1:    bus.rdist <= bus.rd;
                    2'd2:    bus.rdist <= 5'd31;
                    default: bus.rdist <= 5'd0;
                endcase
                busy_op <= bus.ALUOp;
                quo     <= op1;
                dvs     <= op2;
                rem     <= '0;
                cnt     <= (bus.ALUOp == OP_MUL) ? MUL_CNT : DIV_CNT;
                if (!multi) bus.alu_result <= alu_res;
            end else if (state == BUSY && !bus.flush) begin
                if (busy_op != OP_MUL) begin
                    quo <= quo_n;
                    rem <= rem_n;
                end
                if (cnt == '0) bus.alu_result <= fin_res;
                else           cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_execution_pipe.sv
// Scoreboard bench for execution_pipe: driver pushes model results on accept,
// monitor pops and compares whenever an output is consumed.
module tb_execution_pipe;
    localparam int DW = 32, IW = 16, ML = 3;

    logic clk = 1'b0, rstd = 1'b0;
    always #5 clk = ~clk;

    execution_pipe_if #(.DATA_WIDTH(DW), .INST_MEM_WIDTH(IW)) bus ();
    execution_pipe #(.DATA_WIDTH(DW), .INST_MEM_WIDTH(IW), .MUL_LAT(ML)) dut (
        .clk(clk), .rstd(rstd), .bus(bus));

    typedef struct {
        logic [DW-1:0]  res, rdata;
        logic [4:0]     rdist;
        logic [IW-1:0]  pc2;
        logic [127:0]   pass;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, errors = 0, cyc = 0, start;
    bit rand_rdy = 0, ok, seen;
    logic [DW-1:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pass_in();
        return {62'd0, bus.RegWrite, bus.MemWrite, bus.MemRead, bus.UARTtoReg, bus.MemtoReg,
                bus.Branch, bus.inst_index, bus.pc, bus.pc1};
    endfunction

    function automatic logic [127:0] pass_out();
        return {62'd0, bus.RegWrite_next, bus.MemWrite_next, bus.MemRead_next, bus.UARTtoReg_next,
                bus.MemtoReg_next, bus.Branch_next, bus.inst_index_next, bus.pc_next, bus.pc1_next};
    endfunction

    // Reference model straight from the opcode table.
    function automatic exp_t model();
        exp_t e;
        logic [DW-1:0] a, b;
        int sh;
        case (bus.ALUSrcs)
            2'd0: b = bus.op2_sub;
            2'd1: b = DW'(bus.sa);
            2'd2: b = DW'(int'($signed(bus.immediate)));
            default: b = DW'(bus.immediate);
        endcase
        a  = bus.ALUSrcs2 ? bus.op2_sub : bus.op1_sub;
        sh = int'(b % 32);
        case (bus.ALUOp)
            4'd0:  e.res = a + b;
            4'd1:  e.res = a - b;
            4'd2:  e.res = a & b;
            4'd3:  e.res = a | b;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ~(a | b);
            4'd6:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  e.res = a << sh;
            4'd8:  e.res = a >> sh;
            4'd9:  e.res = DW'($signed(a) >>> sh);
            4'd10: e.res = b * 32'd65536;
            4'd11: e.res = DW'(64'(a) * 64'(b));
            4'd12: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: e.res = (b == 0) ? a : a % b;
            default: e.res = '0;
        endcase
        case (bus.RegDist)
            2'd0: e.rdist = bus.rt;
            2'd1: e.rdist = bus.rd;
            2'd2: e.rdist = 5'd31;
            default: e.rdist = 5'd0;
        endcase
        e.pc2   = IW'(int'(bus.pc) + int'($signed(bus.immediate)));
        e.rdata = bus.op1_sub;
        e.pass  = pass_in();
        return e;
    endfunction

    task automatic rand_fields(input bit single_only);
        int r;
        bus.RegWrite = 1'($urandom); bus.MemWrite = 1'($urandom);
        bus.MemRead = 1'($urandom); bus.UARTtoReg = 1'($urandom);
        bus.MemtoReg = 2'($urandom); bus.Branch = 2'($urandom);
        bus.ALUSrcs = 2'($urandom); bus.ALUSrcs2 = 1'($urandom); bus.RegDist = 2'($urandom);
        bus.op1_sub = $urandom;
        r = $urandom_range(0, 7);
        bus.op2_sub = (r == 0) ? 32'd0 : (r < 3) ? 32'($urandom_range(1, 300)) : $urandom;
        bus.rt = 5'($urandom); bus.rd = 5'($urandom); bus.sa = 5'($urandom);
        bus.immediate = 16'($urandom); bus.inst_index = 26'($urandom);
        bus.pc = 16'($urandom); bus.pc1 = 16'($urandom);
        if (single_only) begin
            r = $urandom_range(0, 12);
            bus.ALUOp = 4'((r > 10) ? r + 3 : r);
        end else bus.ALUOp = 4'($urandom_range(0, 15));
    endtask

    task automatic set_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        rand_fields(1);
        bus.ALUOp = op; bus.ALUSrcs = 2'd0; bus.ALUSrcs2 = 1'b0;
        bus.op1_sub = a; bus.op2_sub = b;
    endtask

    // Holds in_valid until accepted; the expected result is queued at the accept edge.
    task automatic send(output bit acc);
        int w = 0;
        acc = 0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && w < 300) begin @(negedge clk); w++; end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", w);
            bus.in_valid = 1'b0;
            return;
        end
        sbq.push_back(model());
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        acc = 1;
    endtask

    // Counts edges from the accept edge to out_valid; in_ready must stay low while busy.
    task automatic wait_out(input int exp_lat, input string name);
        int lat = 1;
        bit busy_ok = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 0;
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 128'(lat), 128'(exp_lat));
        if (exp_lat > 1) chk({name, "_busy_in_ready_low"}, 128'(busy_ok), 128'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        sbq.delete();
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstd && !bus.flush && bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: alu_result %0h with empty scoreboard", bus.alu_result);
                end else begin
                    e = sbq.pop_front();
                    chk("alu_result", 128'(bus.alu_result), 128'(e.res));
                    chk("rdist", 128'(bus.rdist), 128'(e.rdist));
                    chk("pc2", 128'(bus.pc2), 128'(e.pc2));
                    chk("register_data", 128'(bus.register_data), 128'(e.rdata));
                    chk("pass_through", pass_out(), e.pass);
                end
            end
        end
    end

    initial begin : rdy_driver
        forever begin
            @(posedge clk);
            if (rand_rdy) begin #1; bus.out_ready = 1'($urandom_range(0, 1)); end
        end
    end

    initial begin : driver
        rand_fields(1);
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstd = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_alu_result", 128'(bus.alu_result), 128'd0);
        chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset_pc2", 128'(bus.pc2), 128'd0);
        @(posedge clk); #1;

        set_op(4'd0, 32'hFFFF_FFFF, 32'd0); bus.ALUSrcs = 2'd2; bus.immediate = 16'h0001;
        send(ok); wait_out(1, "add");
        chk("add_wrap", 128'(bus.alu_result), 128'd0);
        set_op(4'd9, 32'h8000_0000, 32'd0); bus.ALUSrcs = 2'd1; bus.sa = 5'd4;
        send(ok); wait_out(1, "sra");
        chk("sra", 128'(bus.alu_result), 128'hF800_0000);

        set_op(4'd12, 32'd100, 32'd7); send(ok); wait_out(33, "divu");
        chk("divu_100_7", 128'(bus.alu_result), 128'd14);
        set_op(4'd13, 32'd100, 32'd7); send(ok); wait_out(33, "remu");
        chk("remu_100_7", 128'(bus.alu_result), 128'd2);
        set_op(4'd12, 32'd5, 32'd0); send(ok); wait_out(33, "divu0");
        chk("divu_by_zero", 128'(bus.alu_result), 128'hFFFF_FFFF);
        set_op(4'd13, 32'd5, 32'd0); send(ok); wait_out(33, "remu0");
        chk("remu_by_zero", 128'(bus.alu_result), 128'd5);

        set_op(4'd11, 32'h0001_0000, 32'h0001_0000); send(ok); wait_out(3, "mul_big");
        chk("mul_overflow_low", 128'(bus.alu_result), 128'd0);
        set_op(4'd11, 32'd7, 32'd6); send(ok); wait_out(3, "mul");
        chk("mul_7_6", 128'(bus.alu_result), 128'd42);

        set_op(4'd0, 32'd1, 32'd2); bus.pc = 16'hFFFF; bus.immediate = 16'h0002; bus.RegDist = 2'd2;
        send(ok); wait_out(1, "pcwrap");
        chk("pc2_wrap", 128'(bus.pc2), 128'd1);
        chk("rdist_31", 128'(bus.rdist), 128'd31);

        // Back-to-back: one op per cycle with out_ready held high.
        start = cyc;
        for (int i = 0; i < 6; i++) begin rand_fields(1); send(ok); end
        chk("back_to_back_cycles", 128'(cyc - start), 128'd6);

        // Two-cycle downstream stall with a new op waiting.
        bus.out_ready = 1'b0;
        rand_fields(1);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("stall_in_ready", 128'(bus.in_ready), 128'd0);
        snap = bus.alu_result;
        @(negedge clk);
        chk("stall_in_ready2", 128'(bus.in_ready), 128'd0);
        chk("stall_out_valid", 128'(bus.out_valid), 128'd1);
        chk("stall_frozen", 128'(bus.alu_result), 128'(snap));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(ok); wait_out(1, "after_stall");

        // Flush in the middle of a divide.
        set_op(4'd12, $urandom, 32'd3); send(ok);
        repeat (9) @(posedge clk);
        #1 do_flush();
        @(negedge clk);
        chk("flush_div_out_valid", 128'(bus.out_valid), 128'd0);
        chk("flush_div_in_ready", 128'(bus.in_ready), 128'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (bus.out_valid) seen = 1; end
        chk("flush_div_no_result", 128'(seen), 128'd0);
        @(posedge clk); #1;

        // Flush while holding a result that downstream would take.
        rand_fields(1); send(ok);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("hold_before_flush", 128'(bus.out_valid), 128'd1);
        sbq.delete();
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_hold_dropped", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;

        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            if ($urandom_range(0, 24) == 0) do_flush();
            rand_fields(0);
            send(ok);
        end
        rand_rdy = 0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        repeat (50) @(posedge clk);
        chk("drain_empty", 128'(sbq.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
